vga_sync_gen: RTL

Free-running VGA 640x480@60 timing generator. Produces the horizontal/vertical pixel counters and negative-polarity HSYNC/VSYNC that the horizontal display decoder and the sprite pipeline consume. Sits directly upstream of the horizontal display decoder: its `H_Counts`/`HSYNC` feed that block unchanged. Runs from the 50 MHz board clock, with an optional internal divide-by-2 pixel tick.

---
 rtl/vga_timing_pkg.sv | 52 +++++
 rtl/vga_axis_counter.sv | 47 ++++
 rtl/vga_sync_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Brief    : 640x480@60 default timing, derived totals/boundaries and the
//             region enum shared by the sync generator and display decoders.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;

    localparam int unsigned H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

    localparam int unsigned H_ACT_START = DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned H_ACT_END   = H_ACT_START + DEF_H_ACTIVE;
    localparam int unsigned V_ACT_START = DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned V_ACT_END   = V_ACT_START + DEF_V_ACTIVE;

    typedef enum logic [1:0] {
        SYNC        = 2'd0,
        BACK_PORCH  = 2'd1,
        ACTIVE      = 2'd2,
        FRONT_PORCH = 2'd3
    } vga_region_t;

    // Regions are laid out sync -> back porch -> active -> front porch from 0.
    function automatic vga_region_t region_of(
        input int unsigned pos,
        input int unsigned sync_w,
        input int unsigned bp_w,
        input int unsigned act_w
    );
        if (pos < sync_w)
            return SYNC;
        else if (pos < sync_w + bp_w)
            return BACK_PORCH;
        else if (pos < sync_w + bp_w + act_w)
            return ACTIVE;
        else
            return FRONT_PORCH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_axis_counter
//  Brief    : 10-bit position counter that wraps at TOTAL-1; exposes its
//             next-state value and a wrap strobe for cascading.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
    parameter int unsigned TOTAL = 800
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    output logic [9:0] o_count,
    output logic [9:0] o_next,
    output logic       o_wrap
);

    localparam logic [9:0] c_last = 10'(TOTAL - 1);

    logic [9:0] r_count;
    logic [9:0] w_next;

    // Wrap is an explicit compare so non-power-of-two totals work.
    always_comb begin
        w_next = r_count;
        if (i_inc) begin
            if (r_count == c_last)
                w_next = 10'd0;
            else
                w_next = r_count + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= 10'd0;
        else
            r_count <= w_next;
    end

    assign o_count = r_count;
    assign o_next  = w_next;
    assign o_wrap  = i_inc && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_gen
//  Brief    : Free-running VGA timing generator (counters, negative syncs,
//             video-on and line/frame start flags). Define
//             VGA_SYNC_PIX_DIV2_EN for an internal divide-by-2 pixel tick.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       Enable,
    output logic       Pix_Tick,
    output logic [9:0] H_Counts,
    output logic [9:0] V_Counts,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       Video_On,
    output logic       Line_Start,
    output logic       Frame_Start
);

    localparam int unsigned c_h_total = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned c_v_total = V_SYNC + V_BP + V_ACTIVE + V_FP;

    if (c_h_total > 1024 || c_v_total > 1024) begin : g_bad_total
        $error("vga_sync_gen: H/V totals must not exceed 1024");
    end

    logic        w_adv;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;
    vga_region_t w_h_reg;
    vga_region_t w_v_reg;

    logic r_pix_tick;
    logic r_hsync;
    logic r_vsync;
    logic r_video_on;
    logic r_line_start;
    logic r_frame_start;

`ifdef VGA_SYNC_PIX_DIV2_EN
    logic r_phase;

    // Phase only moves on enabled edges, so a pause never skips a pixel.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_phase <= 1'b0;
        else if (Enable)
            r_phase <= ~r_phase;
    end

    assign w_adv = Enable & r_phase;
`else
    assign w_adv = Enable;
`endif

    vga_axis_counter #(
        .TOTAL (c_h_total)
    ) u_h_cnt (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_inc   (w_adv),
        .o_count (H_Counts),
        .o_next  (w_h_next),
        .o_wrap  (w_h_wrap)
    );

    vga_axis_counter #(
        .TOTAL (c_v_total)
    ) u_v_cnt (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_inc   (w_h_wrap),
        .o_count (V_Counts),
        .o_next  (w_v_next),
        .o_wrap  (w_v_wrap)
    );

    // Flags derive from the next counts so they land with the counters.
    assign w_h_reg = region_of(32'(w_h_next), H_SYNC, H_BP, H_ACTIVE);
    assign w_v_reg = region_of(32'(w_v_next), V_SYNC, V_BP, V_ACTIVE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pix_tick    <= 1'b0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b1;
        end else begin
            r_pix_tick    <= w_adv;
            r_hsync       <= (w_h_reg != SYNC);
            r_vsync       <= (w_v_reg != SYNC);
            r_video_on    <= (w_h_reg == ACTIVE) && (w_v_reg == ACTIVE);
            r_line_start  <= (w_h_next == 10'd0);
            r_frame_start <= (w_h_next == 10'd0) && (w_v_next == 10'd0);
        end
    end

    assign Pix_Tick    = r_pix_tick;
    assign HSYNC       = r_hsync;
    assign VSYNC       = r_vsync;
    assign Video_On    = r_video_on;
    assign Line_Start  = r_line_start;
    assign Frame_Start = r_frame_start;

endmodule
`default_nettype wire
